// File: rtl/uart_pkg.sv
// Shared types and helpers for the serial receive front-end: FSM states,
// frame constants, bit-period derivation and the 3-sample majority vote.
package uart_pkg;

  localparam int DATA_BITS = 8;
  localparam int STOP_BITS = 1;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    STOP      = 3'd3,
    WAIT_IDLE = 3'd4
  } rx_state_t;

  function automatic int calc_clks_per_bit(input int clk_freq, input int baud);
    return clk_freq / baud;
  endfunction

  function automatic logic majority3(input logic [2:0] v);
    return (v[0] & v[1]) | (v[0] & v[2]) | (v[1] & v[2]);
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous input, with a selectable
// reset value so idle-high lines come out of reset in their idle state.
module sync_2ff #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  // metastability filter: d -> meta -> q
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx_byte.sv
// 8N1 UART receiver: start-bit validation, centre sampling, framing-error
// reporting. Define UART_RX_MAJORITY_EN to vote each sample over 3 clocks.
module uart_rx_byte
  import uart_pkg::*;
#(
  parameter int CLK_FREQ = 50000000,
  parameter int BAUD     = 115200
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rxd,
  output logic       rxReady,
  output logic [7:0] rxData,
  output logic       frame_err,
  output logic       busy
);

  localparam int CLKS_PER_BIT = calc_clks_per_bit(CLK_FREQ, BAUD);
  localparam int HALF_BIT     = CLKS_PER_BIT / 2;
  localparam int CW           = $clog2(CLKS_PER_BIT);

  localparam logic [CW-1:0] CNT_ZERO  = CW'(0);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);
  localparam logic [CW-1:0] CNT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_HALF  = CW'(HALF_BIT - 1);
  localparam logic [2:0]    BIDX_LAST = 3'(DATA_BITS - 1);

  generate
    if (CLKS_PER_BIT < 4 || STOP_BITS != 1) begin : g_bad_cfg
      $error("uart_rx_byte: CLKS_PER_BIT must be >= 4 with one stop bit");
    end
  endgenerate

  rx_state_t     state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic [2:0]    bidx, bidx_nx;
  logic [7:0]    sh, sh_nx;
  logic [7:0]    data_nx;
  logic          ready_nx, ferr_nx;
  logic          rxd_s;
  logic          s;

  sync_2ff #(.RST_VAL(1'b1)) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (rxd),
    .q     (rxd_s)
  );

`ifdef UART_RX_MAJORITY_EN
  // two previous synchronised samples; with rxd_s they form the voting window
  logic [1:0] hist;

  // sample history, idle-high after reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hist <= 2'b11;
    end else begin
      hist <= {hist[0], rxd_s};
    end
  end

  assign s = majority3({hist, rxd_s});
`else
  assign s = rxd_s;
`endif

  // next-state and output decode
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    bidx_nx  = bidx;
    sh_nx    = sh;
    data_nx  = rxData;
    ready_nx = 1'b0;
    ferr_nx  = 1'b0;
    case (state)
      IDLE: begin
        cnt_nx = CNT_ZERO;
        if (!rxd_s) begin
          state_nx = START;
        end else begin
          state_nx = IDLE;
        end
      end
      START: begin
        cnt_nx = cnt + CNT_ONE;
        if (cnt == CNT_HALF) begin
          cnt_nx  = CNT_ZERO;
          bidx_nx = 3'd0;
          // a start bit that has gone high by its centre is a glitch
          if (!s) begin
            state_nx = DATA;
          end else begin
            state_nx = IDLE;
          end
        end else begin
          state_nx = START;
        end
      end
      DATA: begin
        cnt_nx = cnt + CNT_ONE;
        if (cnt == CNT_LAST) begin
          cnt_nx = CNT_ZERO;
          sh_nx  = {s, sh[7:1]};
          if (bidx == BIDX_LAST) begin
            state_nx = STOP;
          end else begin
            bidx_nx = bidx + 3'd1;
          end
        end else begin
          state_nx = DATA;
        end
      end
      STOP: begin
        cnt_nx = cnt + CNT_ONE;
        if (cnt == CNT_LAST) begin
          cnt_nx = CNT_ZERO;
          if (s) begin
            data_nx  = sh;
            ready_nx = 1'b1;
            state_nx = IDLE;
          end else begin
            ferr_nx  = 1'b1;
            state_nx = WAIT_IDLE;
          end
        end else begin
          state_nx = STOP;
        end
      end
      WAIT_IDLE: begin
        // hold off until the line returns high so a break yields one error
        cnt_nx = CNT_ZERO;
        if (rxd_s) begin
          state_nx = IDLE;
        end else begin
          state_nx = WAIT_IDLE;
        end
      end
      default: begin
        cnt_nx   = CNT_ZERO;
        state_nx = IDLE;
      end
    endcase
  end

  // state and registered outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= CNT_ZERO;
      bidx      <= 3'd0;
      sh        <= 8'h00;
      rxData    <= 8'h00;
      rxReady   <= 1'b0;
      frame_err <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_nx;
      cnt       <= cnt_nx;
      bidx      <= bidx_nx;
      sh        <= sh_nx;
      rxData    <= data_nx;
      rxReady   <= ready_nx;
      frame_err <= ferr_nx;
      busy      <= (state_nx != IDLE);
    end
  end

endmodule

// File: tb/tb_uart_rx_byte.sv
// Self-checking bench for uart_rx_byte at 10 clocks per bit; expected strobes
// are scheduled from the frame timing rule and compared every cycle.
module tb_uart_rx_byte;

  localparam int CPB  = 10;
  localparam int HALF = CPB / 2;
  localparam int MAXC = 4096;
  // line driven after edge E0 is seen by the FSM at E0+3; stop sampled HALF+9*CPB later
  localparam int STROBE_OFS = 3 + HALF + 9 * CPB;

  logic       clk;
  logic       rst_n;
  logic       rxd;
  logic       rxReady;
  logic [7:0] rxData;
  logic       frame_err;
  logic       busy;

  int cyc = 0;
  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  bit         exp_rdy  [MAXC];
  bit         exp_err  [MAXC];
  bit         rst_at   [MAXC];
  logic [7:0] exp_byte [MAXC];
  logic [7:0] model_data = 8'h00;
  int rdy_cnt = 0;
  int err_cnt = 0;
  int last_rdy_cyc = 0;
  int last_err_cyc = 0;

  uart_rx_byte #(.CLK_FREQ(1000000), .BAUD(100000)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rxd       (rxd),
    .rxReady   (rxReady),
    .rxData    (rxData),
    .frame_err (frame_err),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // per-cycle comparison against the scheduled model
  initial begin
    forever begin
      @(negedge clk);
      if (chk_en && cyc < MAXC) begin
        if (rst_at[cyc]) model_data = 8'h00;
        if (exp_rdy[cyc]) model_data = exp_byte[cyc];
        check("rxReady", {31'd0, rxReady}, {31'd0, exp_rdy[cyc]});
        check("frame_err", {31'd0, frame_err}, {31'd0, exp_err[cyc]});
        check("rxData", {24'd0, rxData}, {24'd0, model_data});
        if (rxReady) begin rdy_cnt++; last_rdy_cyc = cyc; end
        if (frame_err) begin err_cnt++; last_err_cyc = cyc; end
      end
    end
  end

  task automatic drive(input logic v, input int n);
    rxd = v;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input bit glitch3);
    int e0;
    logic [7:0] exp_b;
    e0 = cyc;
    exp_b = b;
`ifndef UART_RX_MAJORITY_EN
    if (glitch3) exp_b[3] = ~b[3];
`endif
    exp_rdy[e0 + STROBE_OFS]  = 1'b1;
    exp_byte[e0 + STROBE_OFS] = exp_b;
    drive(1'b0, CPB);
    for (int k = 0; k < 8; k++) begin
      if (glitch3 && k == 3) begin
        drive(b[k], 5);
        drive(~b[k], 1);
        drive(b[k], 4);
      end else begin
        drive(b[k], CPB);
      end
    end
    drive(1'b1, CPB);
  endtask

  initial begin
    int e0;
    int base_r;
    int base_e;
    int n;
    logic [7:0] b81;
    rst_n = 1'b0;
    rxd   = 1'b1;
    drive(1'b1, 3);
    check("reset_rxReady", {31'd0, rxReady}, 32'd0);
    check("reset_frame_err", {31'd0, frame_err}, 32'd0);
    check("reset_rxData", {24'd0, rxData}, 32'h00);
    check("reset_busy", {31'd0, busy}, 32'd0);
    rst_n  = 1'b1;
    chk_en = 1'b1;
    drive(1'b1, 20);

    // 1: single frame, latency from synchronised start edge
    base_r = rdy_cnt; base_e = err_cnt; e0 = cyc;
    fork
      send_frame(8'hA5, 1'b0);
      begin
        repeat (50) @(posedge clk);
        #1;
        check("t1_busy_mid", {31'd0, busy}, 32'd1);
      end
    join
    check("t1_rdy_count", rdy_cnt - base_r, 32'd1);
    check("t1_latency", last_rdy_cyc - (e0 + 2), 32'd96);
    check("t1_data", {24'd0, rxData}, 32'hA5);
    check("t1_err_count", err_cnt - base_e, 32'd0);
    drive(1'b1, 20);

    // 2: short low pulse rejected
    base_r = rdy_cnt; base_e = err_cnt;
    drive(1'b0, 3);
    rxd = 1'b1;
    n = 0;
    while (busy && n < 6) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("t2_busy_drop", {31'd0, busy}, 32'd0);
    drive(1'b1, 30);
    check("t2_rdy_count", rdy_cnt - base_r, 32'd0);
    check("t2_err_count", err_cnt - base_e, 32'd0);

    // 3: 20-bit break then a good frame
    base_r = rdy_cnt; base_e = err_cnt; e0 = cyc;
    exp_err[e0 + STROBE_OFS] = 1'b1;
    drive(1'b0, 20 * CPB);
    drive(1'b1, 20);
    check("t3_err_count", err_cnt - base_e, 32'd1);
    check("t3_err_cycle", last_err_cyc - e0, 32'd98);
    check("t3_rdy_count", rdy_cnt - base_r, 32'd0);
    check("t3_busy_idle", {31'd0, busy}, 32'd0);
    send_frame(8'h3C, 1'b0);
    check("t3_data", {24'd0, rxData}, 32'h3C);
    check("t3_rdy_after", rdy_cnt - base_r, 32'd1);
    drive(1'b1, 20);

    // 4: back-to-back frames, no idle gap
    base_r = rdy_cnt; base_e = err_cnt;
    send_frame(8'h00, 1'b0);
    send_frame(8'hFF, 1'b0);
    send_frame(8'h55, 1'b0);
    check("t4_rdy_count", rdy_cnt - base_r, 32'd3);
    check("t4_data", {24'd0, rxData}, 32'h55);
    check("t4_err_count", err_cnt - base_e, 32'd0);
    drive(1'b1, 20);

    // 5: reset during data bit 4 of 0x81, then a clean frame
    base_r = rdy_cnt; base_e = err_cnt; e0 = cyc;
    b81 = 8'h81;
    drive(1'b0, CPB);
    for (int k = 0; k < 4; k++) drive(b81[k], CPB);
    drive(b81[4], 3);
    rst_n = 1'b0;
    rxd   = 1'b1;
    rst_at[e0 + 54] = 1'b1;
    @(posedge clk);
    #1;
    check("t5_rst_rxReady", {31'd0, rxReady}, 32'd0);
    check("t5_rst_frame_err", {31'd0, frame_err}, 32'd0);
    check("t5_rst_rxData", {24'd0, rxData}, 32'h00);
    check("t5_rst_busy", {31'd0, busy}, 32'd0);
    rst_n = 1'b1;
    drive(1'b1, 30);
    check("t5_no_strobe", rdy_cnt - base_r, 32'd0);
    send_frame(8'h7E, 1'b0);
    check("t5_data", {24'd0, rxData}, 32'h7E);
    check("t5_err_count", err_cnt - base_e, 32'd0);
    drive(1'b1, 20);

    // 6: one-cycle glitch at the centre of bit 3
    send_frame(8'h5A, 1'b1);
`ifdef UART_RX_MAJORITY_EN
    check("t6_glitch_data", {24'd0, rxData}, 32'h5A);
`else
    check("t6_glitch_data", {24'd0, rxData}, 32'h52);
`endif
    drive(1'b1, 10);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
